// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with external-select or round-robin
// arbitration, packet locking on the last flag, and a registered output stage.
module stream_mux_arb #(
   parameter int N_CH = 4,
   parameter int DW   = 2,
   parameter int SELW = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic [N_CH*DW-1:0] in_data,
   input  logic [N_CH-1:0]    in_valid,
   input  logic [N_CH-1:0]    in_last,
   output logic [N_CH-1:0]    in_ready,
   output logic [DW-1:0]      out_data,
   output logic               out_valid,
   output logic               out_last,
   output logic [SELW-1:0]    out_ch,
   input  logic               out_ready
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state;
   logic [SELW-1:0] lock_ch;
   logic [SELW-1:0] rr_ptr;
   logic [SELW-1:0] grant;
   logic            rr_found;
   logic            grant_ok;
   logic            grant_last;
   logic [DW-1:0]   grant_data;
   logic            load_en;
   logic            accept;

   assign load_en = !out_valid || out_ready;

   always_comb begin
      grant      = '0;
      rr_found   = 1'b0;
      grant_ok   = 1'b0;
      grant_last = 1'b0;
      grant_data = '0;
      in_ready   = '0;

      if (state == LOCKED) begin
         grant = lock_ch;
      end else if (!mode) begin
         grant = sel;
      end else begin
         // Scan starts one past the last channel that finished a packet.
         for (int i = 1; i <= N_CH; i++) begin
            for (int k = 0; k < N_CH; k++) begin
               if (!rr_found && in_valid[k] && (k == (int'(rr_ptr) + i) % N_CH)) begin
                  rr_found = 1'b1;
                  grant    = SELW'(k);
               end
            end
         end
      end

      // An out-of-range select matches no channel, so nothing is granted.
      for (int k = 0; k < N_CH; k++) begin
         if (int'(grant) == k) begin
            grant_ok   = in_valid[k];
            grant_last = in_last[k];
            grant_data = in_data[k*DW +: DW];
         end
      end

      for (int k = 0; k < N_CH; k++) begin
         in_ready[k] = grant_ok && load_en && (int'(grant) == k);
      end
   end

   assign accept = grant_ok && load_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lock_ch   <= '0;
         rr_ptr    <= SELW'(N_CH - 1);
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_ch    <= '0;
      end else begin
         if (load_en) begin
            out_valid <= accept;
            if (accept) begin
               out_data <= grant_data;
               out_last <= grant_last;
               out_ch   <= grant;
            end
         end
         if (accept) begin
            if (grant_last) begin
               state  <= IDLE;
               rr_ptr <= grant;
            end else begin
               state   <= LOCKED;
               lock_ch <= grant;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: directed scenarios plus randomized traffic, all
// checked against a transaction-level arbitration model.
module tb_stream_mux_arb;

   localparam int N    = 4;
   localparam int DW   = 2;
   localparam int SELW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            mode;
   logic [SELW-1:0] sel;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_ready;
   logic [DW-1:0]   out_data;
   logic            out_valid;
   logic            out_last;
   logic [SELW-1:0] out_ch;
   logic            out_ready;

   logic            mode3;
   logic [SELW-1:0] sel3;
   logic [3*DW-1:0] in_data3;
   logic [2:0]      in_valid3;
   logic [2:0]      in_last3;
   logic [2:0]      in_ready3;
   logic [DW-1:0]   out_data3;
   logic            out_valid3;
   logic            out_last3;
   logic [SELW-1:0] out_ch3;
   logic            out_ready3;

   stream_mux_arb #(.N_CH(N), .DW(DW), .SELW(SELW)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ch(out_ch),
      .out_ready(out_ready)
   );

   stream_mux_arb #(.N_CH(3), .DW(DW), .SELW(SELW)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
      .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
      .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3), .out_ch(out_ch3),
      .out_ready(out_ready3)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: one output slot, an optional locked channel, and the channel that
   // most recently finished a packet (round-robin restarts after it).
   int          m_lock, m_last, m_od, m_och, g_ch;
   bit          m_ov, m_ol, m_load, g_ok;
   logic [N-1:0] exp_ready;

   function automatic void model_reset();
      m_lock = -1;
      m_last = N - 1;
      m_ov   = 1'b0;
      m_ol   = 1'b0;
      m_od   = 0;
      m_och  = 0;
   endfunction

   function automatic void model_grant();
      logic [N-1:0] one;
      one    = 1;
      m_load = !m_ov || out_ready;
      g_ok   = 1'b0;
      g_ch   = 0;
      if (m_lock >= 0) begin
         g_ch = m_lock;
         g_ok = in_valid[m_lock];
      end else if (mode == 1'b0) begin
         g_ch = int'(sel);
         g_ok = (g_ch < N) && in_valid[g_ch];
      end else begin
         for (int d = 1; d <= N; d++) begin
            int c;
            c = (m_last + d) % N;
            if (!g_ok && in_valid[c]) begin
               g_ok = 1'b1;
               g_ch = c;
            end
         end
      end
      exp_ready = (g_ok && m_load) ? (one << g_ch) : '0;
   endfunction

   function automatic void model_commit();
      if (m_load) begin
         if (g_ok) begin
            m_ov  = 1'b1;
            m_od  = int'(in_data[g_ch*DW +: DW]);
            m_ol  = in_last[g_ch];
            m_och = g_ch;
            if (in_last[g_ch]) begin
               m_lock = -1;
               m_last = g_ch;
            end else begin
               m_lock = g_ch;
            end
         end else begin
            m_ov = 1'b0;
         end
      end
   endfunction

   task automatic step();
      #1;
      model_grant();
      check_val("in_ready", in_ready, exp_ready);
      @(posedge clk);
      model_commit();
      #1;
      check_val("out_valid", out_valid, m_ov);
      check_val("out_data", out_data, m_od);
      check_val("out_last", out_last, m_ol);
      check_val("out_ch", out_ch, m_och);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = '0;
      #1;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_data", out_data, 0);
      check_val("rst_out_ch", out_ch, 0);
      check_val("rst_out_last", out_last, 0);
      check_val("rst_in_ready", in_ready, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] held;
      rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
      mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; in_last3 = '0; out_ready3 = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_val("init_out_valid", out_valid, 0);
      check_val("init_out_ch", out_ch, 0);
      rst_n = 1'b1;

      // External select, single-beat packets at full rate.
      mode = 1'b0; sel = 2'd2; in_data = 8'b11_10_01_00; in_valid = 4'hF; in_last = 4'hF;
      #1 check_val("sel2_ready", in_ready, 4'b0100);
      step();
      check_val("sel2_data", out_data, 2'b10);
      check_val("sel2_ch", out_ch, 2);
      for (int i = 0; i < 2; i++) begin
         step();
         check_val("sel2_tput", out_valid, 1);
      end

      // Asynchronous reset while a beat is held in the output register.
      #2;
      do_reset();

      // Round-robin order from reset.
      mode = 1'b1; in_valid = 4'hF; in_last = 4'hF;
      for (int i = 0; i < 5; i++) begin
         step();
         check_val("rr_order", out_ch, i % 4);
      end

      // Round-robin packet lock on ch1.
      do_reset();
      mode = 1'b1; in_valid = 4'b0001; in_last = 4'hF;
      step();
      check_val("lock_pre_ch0", out_ch, 0);
      in_valid = 4'b0111; in_last = 4'b1101;
      step();
      check_val("lock_b0", out_ch, 1);
      step();
      check_val("lock_b1", out_ch, 1);
      in_last = 4'hF;
      step();
      check_val("lock_b2", out_ch, 1);
      step();
      check_val("lock_next", out_ch, 2);

      // Select change mid-packet is deferred until the last beat.
      do_reset();
      mode = 1'b0; sel = 2'd1; in_valid = 4'b1010; in_last = 4'b1101;
      step();
      check_val("sel_lock_b0", out_ch, 1);
      sel = 2'd3;
      step();
      check_val("sel_lock_b1", out_ch, 1);
      in_last = 4'hF;
      step();
      check_val("sel_lock_b2", out_ch, 1);
      step();
      check_val("sel_after", out_ch, 3);

      // Backpressure holds the output beat and blocks all inputs.
      held = out_data;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'($urandom);
         step();
         check_val("bp_ready", in_ready, 0);
         check_val("bp_hold", out_data, held);
      end
      out_ready = 1'b1;
      step();
      check_val("bp_release_vld", out_valid, 1);

      // Three-channel instance: out-of-range select grants nothing.
      in_valid3 = 3'b111; in_last3 = 3'b111; in_data3 = 6'b10_01_11; sel3 = 2'd0;
      @(posedge clk);
      #1;
      check_val("n3_sel0_vld", out_valid3, 1);
      check_val("n3_sel0_data", out_data3, 2'b11);
      sel3 = 2'd3;
      #1 check_val("n3_sel3_ready", in_ready3, 0);
      @(posedge clk);
      #1;
      check_val("n3_sel3_drain", out_valid3, 0);
      in_valid3 = '0;

      // Randomized traffic with one reset in the middle.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
         if ($urandom_range(0, 3) == 0) sel = SELW'($urandom);
         in_valid  = N'($urandom);
         in_last   = N'($urandom & $urandom);
         in_data   = (N*DW)'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         if (cyc == 1500) do_reset();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
